// File: rtl/vg_state_seq.sv
// Vector-generator state sequencer: fetches one- and two-word instructions from
// vector memory, runs a small return stack, and issues one-cycle datapath strobes.
module vg_state_seq #(
    parameter int SP_W = 2
) (
    input  logic        clk_12MHz,
    input  logic        rst_n,
    input  logic        state_clk_en,
    input  logic        vg_go,
    input  logic        vg_reset,
    input  logic        draw_done,
    input  logic [15:0] vmem_data,
    output logic [12:0] vmem_addr,
    output logic [3:0]  curr_state,
    output logic        curr_state2,
    output logic        curr_state3,
    output logic        VMEM_not,
    output logic        halt,
    output logic [15:0] word0,
    output logic [15:0] word1,
    output logic        ld_stat,
    output logic        ld_scal,
    output logic        ld_cntr,
    output logic        draw_start
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_FETCH0 = 4'b1000,
        ST_FETCH1 = 4'b1001,
        ST_DRAW   = 4'b1100
    } state_e;

    state_e            state_q, state_d;
    logic [12:0]       pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              halt_q, halt_d;
    logic              go_pending_q, go_pending_d;
    logic              vmem_n_q, vmem_n_d;
    logic [15:0]       word0_q, word0_d;
    logic [15:0]       word1_q, word1_d;
    // strobe bits: {ld_stat, ld_scal, ld_cntr, draw_start}
    logic [3:0]        strobe_q, strobe_d;

    logic [12:0]       stack_q [0:(2**SP_W)-1];
    logic              stack_we_s;
    logic [12:0]       stack_wdata_s;
    logic [SP_W-1:0]   rts_idx_s;
    logic [2:0]        op_s;
    logic              start_s;

    // Next-state, program counter, stack and strobe decode.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        sp_d          = sp_q;
        halt_d        = halt_q;
        word0_d       = word0_q;
        word1_d       = word1_q;
        strobe_d      = 4'b0000;
        stack_we_s    = 1'b0;
        stack_wdata_s = pc_q + 13'd1;
        rts_idx_s     = sp_q - SP_W'(1);
        op_s          = vmem_data[15:13];
        start_s       = 1'b0;

        if (state_clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (go_pending_q) begin
                        pc_d    = 13'd0;
                        sp_d    = '0;
                        halt_d  = 1'b0;
                        state_d = ST_FETCH0;
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH0: begin
                    word0_d = vmem_data;
                    case (op_s)
                        3'b000: begin
                            pc_d    = pc_q + 13'd1;
                            state_d = ST_FETCH1;
                        end
                        3'b001: begin
                            pc_d    = pc_q + 13'd1;
                            halt_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                        3'b010: begin
                            pc_d        = pc_q + 13'd1;
                            strobe_d[0] = 1'b1;
                            state_d     = ST_DRAW;
                        end
                        3'b011: begin
                            pc_d = pc_q + 13'd1;
                            if (vmem_data[12]) begin
                                strobe_d[2] = 1'b1;
                            end else begin
                                strobe_d[3] = 1'b1;
                            end
                        end
                        3'b100: begin
                            pc_d        = pc_q + 13'd1;
                            strobe_d[1] = 1'b1;
                        end
                        3'b101: begin
                            stack_we_s = 1'b1;
                            sp_d       = sp_q + SP_W'(1);
                            pc_d       = vmem_data[12:0];
                        end
                        3'b110: begin
                            sp_d = rts_idx_s;
                            pc_d = stack_q[rts_idx_s];
                        end
                        3'b111: begin
                            pc_d = vmem_data[12:0];
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                ST_FETCH1: begin
                    word1_d     = vmem_data;
                    pc_d        = pc_q + 13'd1;
                    strobe_d[0] = 1'b1;
                    state_d     = ST_DRAW;
                end
                ST_DRAW: begin
                    if (draw_done) begin
                        state_d = ST_FETCH0;
                    end else begin
                        state_d = ST_DRAW;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // A start consumes the pending request; vg_go is latched on any other clock.
        if (start_s) begin
            go_pending_d = 1'b0;
        end else begin
            go_pending_d = go_pending_q | vg_go;
        end

        // CPU reset strobe behaves exactly like rst_n and wins over everything else.
        if (vg_reset) begin
            state_d      = ST_IDLE;
            pc_d         = 13'd0;
            sp_d         = '0;
            halt_d       = 1'b1;
            go_pending_d = 1'b0;
            word0_d      = 16'd0;
            word1_d      = 16'd0;
            strobe_d     = 4'b0000;
            stack_we_s   = 1'b0;
        end else begin
            stack_we_s   = stack_we_s;
        end

        vmem_n_d = !((state_d == ST_FETCH0) || (state_d == ST_FETCH1));
    end

    // Control and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_12MHz) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= 13'd0;
            sp_q         <= '0;
            halt_q       <= 1'b1;
            go_pending_q <= 1'b0;
            vmem_n_q     <= 1'b1;
            word0_q      <= 16'd0;
            word1_q      <= 16'd0;
            strobe_q     <= 4'b0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            halt_q       <= halt_d;
            go_pending_q <= go_pending_d;
            vmem_n_q     <= vmem_n_d;
            word0_q      <= word0_d;
            word1_q      <= word1_d;
            strobe_q     <= strobe_d;
        end
    end

    // Return-address stack; contents are intentionally not reset.
    always_ff @(posedge clk_12MHz) begin
        if (rst_n && stack_we_s) begin
            stack_q[sp_q] <= stack_wdata_s;
        end
    end

    assign vmem_addr   = pc_q;
    assign curr_state  = state_q;
    assign curr_state2 = state_q[2];
    assign curr_state3 = state_q[3];
    assign VMEM_not    = vmem_n_q;
    assign halt        = halt_q;
    assign word0       = word0_q;
    assign word1       = word1_q;
    assign ld_stat     = strobe_q[3];
    assign ld_scal     = strobe_q[2];
    assign ld_cntr     = strobe_q[1];
    assign draw_start  = strobe_q[0];

endmodule

// File: doc/vg_state_seq.md
VG_STATE_SEQ -- requirements
Module: vg_state_seq

Interface
REQ-001 SHALL have parameter SP_W, default 2, meaning return-stack pointer width (depth 2**SP_W).
REQ-002 SHALL have port clk_12MHz, input, 1, meaning the single clock.
REQ-003 SHALL have port rst_n, input, 1, meaning reset; reset is synchronous and active-low.
REQ-004 SHALL have port state_clk_en, input, 1, meaning a one-clock pulse per state-clock period; the FSM advances only on edges where it is 1.
REQ-005 SHALL have port vg_go, input, 1, meaning a CPU start strobe.
REQ-006 SHALL have port vg_reset, input, 1, meaning a CPU vector-generator reset strobe.
REQ-007 SHALL have port draw_done, input, 1, meaning the vector timer has finished.
REQ-008 SHALL have port vmem_data, input, 16, meaning the vector memory word at vmem_addr; it is valid by the next state_clk_en.
REQ-009 SHALL have port vmem_addr, output, 13, meaning the registered program counter (pc).
REQ-010 SHALL have port curr_state, output, 4, meaning the state code.
REQ-011 SHALL have ports curr_state2 and curr_state3, output, 1 each, meaning curr_state[2] and curr_state[3].
REQ-012 SHALL have port VMEM_not, output, 1, meaning active-low vector-memory fetch.
REQ-013 SHALL have port halt, output, 1, meaning the generator is halted.
REQ-014 SHALL have ports word0 and word1, output, 16 each, meaning the latched instruction words.
REQ-015 SHALL have ports ld_stat, ld_scal, ld_cntr and draw_start, output, 1 each, meaning single-clock datapath strobes.

Function
REQ-016 SHALL use state codes IDLE=4'b0001, FETCH0=4'b1000, FETCH1=4'b1001, DRAW=4'b1100.
REQ-017 SHALL drive VMEM_not=0 in FETCH0/FETCH1 and VMEM_not=1 in IDLE/DRAW.
REQ-018 SHALL set go_pending on any clock where vg_go=1, and clear it on start or on vg_reset.
REQ-019 SHALL, in IDLE at state_clk_en with go_pending=1, set pc=0, sp=0, halt=0 and state=FETCH0.
REQ-020 SHALL ignore vg_go while not in IDLE, with go_pending left set until the next IDLE start.
REQ-021 SHALL, in FETCH0 at state_clk_en, capture word0=vmem_data and decode op=vmem_data[15:13].
REQ-022 SHALL, for op 000 (VCTR), set pc=pc+1 and go to FETCH1.
REQ-023 SHALL, for op 001 (HALT), set pc=pc+1, halt=1 and go to IDLE.
REQ-024 SHALL, for op 010 (SVEC), set pc=pc+1, pulse draw_start and go to DRAW.
REQ-025 SHALL, for op 011, set pc=pc+1, pulse ld_scal if bit12=1 else ld_stat, and stay in FETCH0.
REQ-026 SHALL, for op 100 (CNTR), set pc=pc+1, pulse ld_cntr and stay in FETCH0.
REQ-027 SHALL, for op 101 (JSRL), set stack[sp]=pc+1, sp=sp+1 and pc=vmem_data[12:0], staying in FETCH0.
REQ-028 SHALL, for op 110 (RTSL), set sp=sp-1 and pc=stack[sp-1], staying in FETCH0.
REQ-029 SHALL, for op 111 (JMPL), set pc=vmem_data[12:0] and stay in FETCH0.
REQ-030 SHALL, in FETCH1 at state_clk_en, capture word1=vmem_data, set pc=pc+1, pulse draw_start and go to DRAW.
REQ-031 SHALL, in DRAW at state_clk_en, go to FETCH0 if draw_done=1 and otherwise stay in DRAW.
REQ-032 SHALL assert every strobe for exactly one clk_12MHz cycle, in the cycle after the advancing edge.
REQ-033 SHALL wrap pc modulo 2**13 (0x1FFF+1 -> 0x0000).
REQ-034 SHALL wrap sp modulo 2**SP_W; overflow overwrites the oldest entry, and underflow reads the wrapped entry with no error flag.
REQ-035 SHALL treat a vg_reset=1 clock exactly as reset, taking priority over vg_go and state_clk_en on the same edge.
REQ-036 SHALL hold all state, pc, sp and outputs when state_clk_en=0, except strobe deassertion and go_pending capture.

Reset
REQ-037 SHALL, with rst_n=0 at a clock edge, set state=IDLE, pc=0, sp=0, halt=1, go_pending=0, word0=word1=0 and all strobes=0, regardless of state (including mid-DRAW).
REQ-038 SHALL leave stack contents undefined after reset.

Verification
REQ-039 SHALL cover: memory {0x6012, 0x2000}, vg_go, then state_clk_en every 4 clocks -> one ld_stat pulse, then halt=1, state=IDLE, vmem_addr=2.
REQ-040 SHALL cover: memory {0x0010, 0x0020, 0x2000}, draw_done held 0 for 3 enables then 1 -> word0=0x0010, word1=0x0020, draw_start pulsed once, DRAW held 3 enables, then HALT.
REQ-041 SHALL cover: {0: 0xA005 JSRL, 1: 0x2000, 5: 0xC000 RTSL} -> pc sequence 0, 5, 1, then halt, with sp=0 at the end.
REQ-042 SHALL cover: five nested JSRLs with SP_W=2 -> sp wraps to 1 and the first return address is overwritten.
REQ-043 SHALL cover: JMPL 0xFFFF at 0x0000, then memory at 0x1FFF = 0x8000 (CNTR) -> ld_cntr pulse, after which pc wraps to 0x0000.
REQ-044 SHALL cover: vg_reset and vg_go on the same clock mid-DRAW -> IDLE, halt=1, go_pending=0, and no restart.
